// File: rtl/proc_run_ctrl.sv
// Run-control and reset sequencer for the processor core.
// Holds the core in reset for RST_HOLD edges, then gates the core's PC
// advance according to the selected run mode and PC breakpoints, and
// counts cycles in which the PC was allowed to advance.
module proc_run_ctrl #(
  parameter int RST_HOLD = 2,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16,
  parameter int NUM_BP   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   step,
  input  logic [CNT_W-1:0]       run_count,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   core_reset,
  output logic                   enable_pc_external,
  output logic                   test,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       cycle_cnt
);

  localparam int HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUNN = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                core_reset_q, core_reset_d;
  logic                test_q, test_d;
  logic                halted_q, halted_d;
  logic                en_q, en_d;
  logic                skip_q, skip_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;

  logic                step_eff;
  logic                active;
  logic [NUM_BP-1:0]   bp_match;
  logic                enable;
  logic                stop;

  // Zero-latency breakpoint compare and PC enable; a start pulse masks step.
  always_comb begin
    step_eff = step & ~start;
    active   = (state_q == S_RUN) | ((state_q == S_STEP) & step_eff);
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_en[i] & (pc == bp_addr[i*PC_W +: PC_W]) & active & ~skip_q;
    end
    case (state_q)
      S_RUN:   enable = en_q & ~(|bp_match);
      S_STEP:  enable = step_eff & ~(|bp_match);
      default: enable = 1'b0;
    endcase
  end

  // Next-state logic for the sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_reset_d = core_reset_q;
    test_d       = test_q;
    halted_d     = halted_q;
    en_d         = en_q;
    skip_d       = skip_q;
    remaining_d  = remaining_q;
    cycle_cnt_d  = cycle_cnt_q + CNT_W'(enable);
    bp_hit_d     = bp_hit_q | bp_match;
    stop         = 1'b0;

    case (state_q)
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_d >= HOLD_W'(RST_HOLD)) begin
          core_reset_d = 1'b1;
          test_d       = 1'b1;
          halted_d     = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_IDLE, S_HALT: begin
        en_d     = 1'b0;
        halted_d = 1'b1;
        if (start) begin
          bp_hit_d    = '0;
          skip_d      = 1'b1;
          remaining_d = '0;
          case (mode)
            MODE_FREE: begin
              state_d  = S_RUN;
              en_d     = 1'b1;
              halted_d = 1'b0;
            end
            MODE_STEP: begin
              state_d  = S_STEP;
              halted_d = 1'b0;
            end
            MODE_RUNN: begin
              if (run_count == '0) begin
                state_d = S_HALT;
              end else begin
                state_d     = S_RUN;
                remaining_d = run_count;
                en_d        = 1'b1;
                halted_d    = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        skip_d = 1'b0;
        // Budget only counts down for a run-N launch (remaining is zero otherwise).
        if ((mode == MODE_RUNN) && enable && (remaining_q != '0)) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) stop = 1'b1;
        end
        if (|bp_match) stop = 1'b1;
        if (mode == MODE_HALT) stop = 1'b1;
      end

      S_STEP: begin
        if (step_eff) skip_d = 1'b0;
        if (|bp_match) stop = 1'b1;
        if (mode == MODE_HALT) stop = 1'b1;
      end

      default: state_d = S_HOLD;
    endcase

    if (stop) begin
      state_d  = S_HALT;
      en_d     = 1'b0;
      halted_d = 1'b1;
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b0;
      test_q       <= 1'b0;
      halted_q     <= 1'b0;
      en_q         <= 1'b0;
      skip_q       <= 1'b0;
      remaining_q  <= '0;
      cycle_cnt_q  <= '0;
      bp_hit_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      test_q       <= test_d;
      halted_q     <= halted_d;
      en_q         <= en_d;
      skip_q       <= skip_d;
      remaining_q  <= remaining_d;
      cycle_cnt_q  <= cycle_cnt_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  assign core_reset         = core_reset_q;
  assign test               = test_q;
  assign halted             = halted_q;
  assign bp_hit             = bp_hit_q;
  assign cycle_cnt          = cycle_cnt_q;
  assign enable_pc_external = enable;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: a vector table for reset and
// run-N, directed corner sequences, and randomized traffic checked against
// a behavioural model of the run-control rules.
module tb_proc_run_ctrl;

  localparam int RST_HOLD = 2;
  localparam int PC_W     = 32;
  localparam int CNT_W    = 16;
  localparam int NUM_BP   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             mode;
  logic                   start;
  logic                   step;
  logic [CNT_W-1:0]       run_count;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   core_reset;
  logic                   enable_pc_external;
  logic                   test;
  logic                   halted;
  logic [NUM_BP-1:0]      bp_hit;
  logic [CNT_W-1:0]       cycle_cnt;

  always #5 clk = ~clk;

  proc_run_ctrl #(
    .RST_HOLD(RST_HOLD), .PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .step(step),
    .run_count(run_count), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .core_reset(core_reset), .enable_pc_external(enable_pc_external),
    .test(test), .halted(halted), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model of the controller as seen from outside.
  int                m_hold;
  bit                m_alive;
  bit                m_busy;
  bit                m_stepping;
  bit                m_skip;
  int                m_budget;
  logic [NUM_BP-1:0] m_hits;
  int                m_count;

  logic              last_en;
  logic [PC_W-1:0]   last_pc;

  typedef struct {
    logic [1:0]       mode;
    logic             start;
    logic [CNT_W-1:0] rc;
    logic             exp_en;
    logic             exp_cr;
    logic             exp_halted;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_BP-1:0] model_match();
    logic [NUM_BP-1:0] r;
    bit act;
    r   = '0;
    act = m_busy && (!m_stepping || (step && !start));
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && act && !m_skip && (pc == bp_addr[i*PC_W +: PC_W])) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic model_en(input logic [NUM_BP-1:0] mm);
    return m_busy && (!m_stepping || (step && !start)) && (mm == '0);
  endfunction

  task automatic model_reset();
    m_hold = 0; m_alive = 0; m_busy = 0; m_stepping = 0; m_skip = 0;
    m_budget = -1; m_hits = '0; m_count = 0;
  endtask

  task automatic model_edge(input logic [NUM_BP-1:0] mm, input logic ee);
    bit act;
    if (!m_alive) begin
      m_hold++;
      if (m_hold >= RST_HOLD) m_alive = 1;
    end else if (!m_busy) begin
      if (start) begin
        m_hits = '0;
        m_skip = 1;
        case (mode)
          2'd0: begin m_busy = 1; m_stepping = 0; m_budget = -1; end
          2'd1: begin m_busy = 1; m_stepping = 1; m_budget = -1; end
          2'd2: if (run_count != 0) begin
                  m_busy = 1; m_stepping = 0; m_budget = int'(run_count);
                end
          default: ;
        endcase
      end
    end else begin
      act = !m_stepping || (step && !start);
      if (ee) m_count = (m_count + 1) % (1 << CNT_W);
      if (mode == 2'd2 && ee && m_budget > 0) begin
        m_budget--;
        if (m_budget == 0) m_busy = 0;
      end
      if (mm != '0) begin
        m_hits = m_hits | mm;
        m_busy = 0;
      end
      if (mode == 2'd3) m_busy = 0;
      if (act) m_skip = 0;
    end
  endtask

  task automatic check_regs();
    chk("core_reset", core_reset, m_alive);
    chk("test", test, m_alive);
    chk("halted", halted, m_alive && !m_busy);
    chk("bp_hit", bp_hit, m_hits);
    chk("cycle_cnt", cycle_cnt, m_count);
  endtask

  // One clock: compare the combinational enable mid-cycle, advance the core
  // PC model on the edge, then compare the registered outputs.
  task automatic step_cycle();
    logic [NUM_BP-1:0] mm;
    logic ee;
    @(negedge clk);
    mm      = model_match();
    ee      = model_en(mm);
    last_en = enable_pc_external;
    last_pc = pc;
    chk("enable", enable_pc_external, ee);
    @(posedge clk);
    #1;
    if (last_en) pc = pc + 32'd4;
    model_edge(mm, ee);
    check_regs();
  endtask

  // Pull reset low mid-cycle and confirm outputs clear without a clock edge.
  task automatic do_reset();
    #3;
    reset = 1'b0;
    start = 1'b0;
    step  = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 0);
    chk("rst_enable", enable_pc_external, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_test", test, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bp_hit", bp_hit, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    pc    = '0;
    model_reset();
  endtask

  initial begin
    int n;
    int ens;
    int c0;
    logic found;
    logic [PC_W-1:0] hit_pc;
    logic [6:0] pat;

    reset = 1'b0; mode = 2'd0; start = 1'b0; step = 1'b0; run_count = '0;
    pc = '0; bp_addr = '0; bp_en = '0;
    last_en = 1'b0; last_pc = '0;
    model_reset();

    tbl[0]  = '{2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{2'd2, 1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[2]  = '{2'd2, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{2'd2, 1'b0, 16'd5, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[4]  = '{2'd2, 1'b0, 16'd5, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[5]  = '{2'd2, 1'b0, 16'd5, 1'b1, 1'b1, 1'b0, 16'd3};
    tbl[6]  = '{2'd2, 1'b0, 16'd5, 1'b1, 1'b1, 1'b0, 16'd4};
    tbl[7]  = '{2'd2, 1'b0, 16'd5, 1'b1, 1'b1, 1'b1, 16'd5};
    tbl[8]  = '{2'd2, 1'b0, 16'd5, 1'b0, 1'b1, 1'b1, 16'd5};
    tbl[9]  = '{2'd2, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd5};
    tbl[10] = '{2'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd5};

    // Reset state, then release and walk the vector table.
    #1;
    chk("init_core_reset", core_reset, 0);
    chk("init_test", test, 0);
    chk("init_halted", halted, 0);
    chk("init_enable", enable_pc_external, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mode = tbl[i].mode; start = tbl[i].start; run_count = tbl[i].rc;
      @(negedge clk);
      last_en = enable_pc_external;
      chk("tbl_enable", enable_pc_external, tbl[i].exp_en);
      @(posedge clk);
      #1;
      if (last_en) pc = pc + 32'd4;
      chk("tbl_core_reset", core_reset, tbl[i].exp_cr);
      chk("tbl_test", test, tbl[i].exp_cr);
      chk("tbl_halted", halted, tbl[i].exp_halted);
      chk("tbl_cycle_cnt", cycle_cnt, tbl[i].exp_cnt);
    end
    start = 1'b0;

    // Breakpoint at 0x10, free-run from pc=0, then resume past it.
    do_reset();
    mode = 2'd0;
    step_cycle();
    step_cycle();
    bp_addr[0 +: PC_W]    = 32'h10;
    bp_addr[PC_W +: PC_W] = 32'hFFFF_FFF0;
    bp_en = 2'b01;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    found = 1'b0;
    hit_pc = '0;
    for (int k = 0; k < 20 && !found; k++) begin
      step_cycle();
      if (!last_en) begin
        found  = 1'b1;
        hit_pc = last_pc;
      end
    end
    chk("bp_found", found, 1);
    chk("bp_stall_pc", hit_pc, 32'h10);
    chk("bp_hit_flag", bp_hit, 2'b01);
    chk("bp_halted", halted, 1);
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    chk("bp_cleared", bp_hit, 2'b00);
    repeat (3) step_cycle();
    chk("bp_resume_pc", pc, 32'h1C);
    mode = 2'd3;
    step_cycle();
    step_cycle();

    // Step mode: one step, gap of three, two steps.
    bp_en = '0;
    mode = 2'd1;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    c0 = int'(cycle_cnt);
    ens = 0;
    pat = 7'b0110001;
    for (int k = 0; k < 7; k++) begin
      step = pat[k];
      step_cycle();
      chk("step_coincident", last_en, pat[k]);
      if (last_en) ens++;
    end
    step = 1'b0;
    chk("step_enables", ens, 3);
    chk("step_cnt", int'(cycle_cnt) - c0, 3);
    mode = 2'd3;
    step_cycle();
    chk("step_halted", halted, 1);

    // Halt request while free-running, then async reset mid-run.
    mode = 2'd0;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (3) step_cycle();
    mode = 2'd3;
    step_cycle();
    chk("halt_req_last_en", last_en, 1);
    chk("halt_req_halted", halted, 1);
    step_cycle();
    chk("halt_req_en_low", last_en, 0);
    mode = 2'd0;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (3) step_cycle();
    chk("pre_reset_running", enable_pc_external, 1);
    do_reset();

    // cycle_cnt wrap: 65535 enabled cycles, then one more.
    mode = 2'd0;
    step_cycle();
    step_cycle();
    mode = 2'd2;
    run_count = 16'hFFFF;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    n = 0;
    while (!halted && n < 70000) begin
      step_cycle();
      n++;
    end
    chk("wrap_bound", n < 70000, 1);
    chk("cnt_full", cycle_cnt, 16'hFFFF);
    run_count = 16'd1;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    step_cycle();
    step_cycle();
    chk("cnt_wrap", cycle_cnt, 16'h0000);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 9) == 0);
      step = 1'($urandom_range(0, 1));
      run_count = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) pc = PC_W'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 31) == 0) bp_en = NUM_BP'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        for (int b = 0; b < NUM_BP; b++) bp_addr[b*PC_W +: PC_W] = PC_W'($urandom_range(0, 15) * 4);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
